ifu_fetch_ctrl: RTL and testbench

- Parametrised next-generation instruction fetch unit.
- Holds the fetch PC and fetches one instruction at a time from instruction memory over a valid/ready request channel with a variable-latency response.
- Buffers the fetched word for the D stage.
- Handles exception entry, eret redirect, stall and instruction-address error (AdEL) detection, and discards stale in-flight responses after a redirect.

---
 rtl/ifu_pkg.sv | 20 ++
 rtl/ifu_addr_check.sv | 22 ++
 rtl/ifu_fetch_ctrl.sv | 140 ++++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and default constants for the instruction fetch unit.
package ifu_pkg;

  // Fetch sequencer states: idle/issuing, waiting for a live response,
  // or waiting to swallow a response made stale by a redirect.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  // Instruction word carried by an address-error marker.
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_PC     = 32'h0000_4180;
  localparam logic [31:0] DEF_IMEM_BASE  = 32'h0000_3000;
  localparam logic [31:0] DEF_IMEM_LIMIT = 32'h0000_6FFC;

endpackage

// File: rtl/ifu_addr_check.sv
// Fetch address legality: word aligned and inside the inclusive
// instruction memory window. Purely combinational.
module ifu_addr_check
  import ifu_pkg::*;
#(
  parameter int unsigned           ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]     IMEM_BASE  = ADDR_W'(DEF_IMEM_BASE),
  parameter logic [ADDR_W-1:0]     IMEM_LIMIT = ADDR_W'(DEF_IMEM_LIMIT)
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              addr_ok_o
);

  logic aligned;
  logic in_range;

  // Unsigned full-width compares against both window ends.
  assign aligned   = (addr_i[1:0] == 2'b00);
  assign in_range  = (addr_i >= IMEM_BASE) && (addr_i <= IMEM_LIMIT);
  assign addr_ok_o = aligned && in_range;

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, issues one request at a
// time to instruction memory, buffers the returned word for D, and handles
// exception/eret redirects, stalls and address-error markers.
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEF_RESET_PC),
  parameter logic [ADDR_W-1:0] EXC_PC     = ADDR_W'(DEF_EXC_PC),
  parameter logic [ADDR_W-1:0] IMEM_BASE  = ADDR_W'(DEF_IMEM_BASE),
  parameter logic [ADDR_W-1:0] IMEM_LIMIT = ADDR_W'(DEF_IMEM_LIMIT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exc_req,
  input  logic              eret,
  input  logic [ADDR_W-1:0] epc,
  input  logic              stall,
  input  logic [ADDR_W-1:0] npc,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  output logic              f_valid,
  output logic [31:0]       f_instr,
  output logic [ADDR_W-1:0] f_pc,
  output logic              f_adel
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              adel_q, adel_d;

  logic              addr_ok;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              req_fire;
  logic              consume;

  ifu_addr_check #(
    .ADDR_W     (ADDR_W),
    .IMEM_BASE  (IMEM_BASE),
    .IMEM_LIMIT (IMEM_LIMIT)
  ) u_addr_check (
    .addr_i    (pc_q),
    .addr_ok_o (addr_ok)
  );

  // exc_req outranks eret when both arrive together.
  assign redirect    = exc_req || eret;
  assign redirect_pc = exc_req ? EXC_PC : epc;

  // Request only from an empty buffer with a legal PC; reset and redirect
  // both suppress it so nothing leaves for an address about to change.
  assign imem_req_valid = reset && (state_q == IDLE) && !valid_q && addr_ok && !redirect;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign consume        = valid_q && !stall && !redirect;

  assign f_valid = valid_q;
  assign f_instr = instr_q;
  assign f_pc    = pc_q;
  assign f_adel  = adel_q;

  // Next-state: redirect first, otherwise fetch sequencing plus consume.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    adel_d  = adel_q;

    if (redirect) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      adel_d  = 1'b0;
      case (state_q)
        // A response landing in the redirect cycle closes the transaction
        // immediately; otherwise it is still owed and must be swallowed.
        WAIT:    state_d = imem_resp_valid ? IDLE : DROP;
        // Repeated redirects while draining only move the PC; the one
        // outstanding response still ends the drain when it shows up.
        DROP:    state_d = imem_resp_valid ? IDLE : DROP;
        default: state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            state_d = WAIT;
          end else if (!valid_q && !addr_ok) begin
            // Bad PC: hand D a marker instead of touching memory.
            valid_d = 1'b1;
            adel_d  = 1'b1;
            instr_d = NOP_INSTR;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            instr_d = imem_resp_data;
            valid_d = 1'b1;
            adel_d  = 1'b0;
            state_d = IDLE;
          end
        end
        DROP: begin
          if (imem_resp_valid) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (consume) begin
        valid_d = 1'b0;
        adel_d  = 1'b0;
        pc_d    = npc;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      adel_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      adel_q  <= adel_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Self-checking bench for ifu_fetch_ctrl: directed scenarios followed by a
// randomized run compared against a transaction-level reference model.
module tb_ifu_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_A  = 32'h0000_4180;
  localparam logic [31:0] LO     = 32'h0000_3000;
  localparam logic [31:0] HI     = 32'h0000_6FFC;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        exc_req = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] epc = 32'h0;
  logic        stall = 1'b0;
  logic [31:0] npc = 32'h0;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        f_valid;
  logic [31:0] f_instr;
  logic [31:0] f_pc;
  logic        f_adel;

  int errors = 0;
  int checks = 0;

  // memory responder controls
  int          mem_lat = 2;
  bit          lat_rand = 1'b0;
  bit          use_fixed = 1'b0;
  bit          stray_en = 1'b0;
  logic [31:0] fixed_data = 32'h0;
  int          mem_cnt = 0;
  logic [31:0] mem_pend = 32'h0;
  logic        hs_pending = 1'b0;
  logic [31:0] hs_addr = 32'h0;
  logic        rst_low = 1'b1;

  always #5 clk = ~clk;

  ifu_fetch_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .exc_req         (exc_req),
    .eret            (eret),
    .epc             (epc),
    .stall           (stall),
    .npc             (npc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .f_valid         (f_valid),
    .f_instr         (f_instr),
    .f_pc            (f_pc),
    .f_adel          (f_adel)
  );

  function automatic logic addr_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= LO) && (a <= HI);
  endfunction

  function automatic logic [31:0] mword(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Capture what the coming edge will see (inputs are settled by now).
  always @(negedge clk) begin
    #2;
    hs_pending = imem_req_valid && imem_req_ready;
    hs_addr    = imem_req_addr;
    rst_low    = !reset;
  end

  // Memory: answers a handshake after mem_lat cycles, reset with the DUT.
  always @(posedge clk) begin
    #1;
    imem_resp_valid = 1'b0;
    if (rst_low) begin
      mem_cnt = 0;
    end else begin
      if (hs_pending) begin
        mem_cnt  = lat_rand ? int'($urandom_range(1, 3)) : mem_lat;
        mem_pend = use_fixed ? fixed_data : mword(hs_addr);
      end
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_pend;
        end
      end else if (stray_en && $urandom_range(0, 15) == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = $urandom;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0; imem_req_ready = 1'b1; mem_lat = 2;
    @(negedge clk); #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_during got=%b exp=0", imem_req_valid); end
    @(negedge clk); #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req_valid); end
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL reset_fvalid got=%b exp=0", f_valid); end
    checks++; if (f_pc !== RST_PC) begin errors++; $display("FAIL reset_fpc got=%h exp=%h", f_pc, RST_PC); end
    checks++; if (f_adel !== 1'b0) begin errors++; $display("FAIL reset_fadel got=%b exp=0", f_adel); end
    checks++; if (f_instr !== 32'h0) begin errors++; $display("FAIL reset_finstr got=%h exp=0", f_instr); end
  endtask

  task automatic test_basic_fetch();
    int n;
    use_fixed = 1'b1; fixed_data = 32'h2401_0005; mem_lat = 2; npc = 32'h3004; stall = 1'b0;
    @(negedge clk); reset = 1'b1; #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h3000) begin errors++; $display("FAIL first_req got=%b/%h exp=1/00003000", imem_req_valid, imem_req_addr); end
    n = 0;
    for (int k = 1; k <= 10 && n == 0; k++) begin
      @(negedge clk); #1;
      if (f_valid === 1'b1) n = k;
    end
    checks++; if (n != 3) begin errors++; $display("FAIL fetch_latency got=%0d exp=3", n); end
    checks++; if (f_pc !== 32'h3000) begin errors++; $display("FAIL fetch_fpc got=%h exp=00003000", f_pc); end
    checks++; if (f_instr !== 32'h2401_0005) begin errors++; $display("FAIL fetch_instr got=%h exp=24010005", f_instr); end
    checks++; if (f_adel !== 1'b0) begin errors++; $display("FAIL fetch_adel got=%b exp=0", f_adel); end
    @(negedge clk); #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h3004) begin errors++; $display("FAIL next_req got=%b/%h exp=1/00003004", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_stall();
    int n;
    n = 0;
    for (int k = 1; k <= 10 && n == 0; k++) begin
      @(negedge clk); #1;
      if (f_valid === 1'b1) n = k;
    end
    checks++; if (n == 0) begin errors++; $display("FAIL stall_wait_fetch got=timeout exp=f_valid"); end
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      checks++; if (f_valid !== 1'b1 || f_pc !== 32'h3004 || f_instr !== 32'h2401_0005) begin
        errors++; $display("FAIL stall_hold got=%b/%h/%h exp=1/00003004/24010005", f_valid, f_pc, f_instr);
      end
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_noreq got=%b exp=0", imem_req_valid); end
    end
    stall = 1'b0; npc = 32'h3008;
    @(negedge clk); #1;
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL stall_release_fvalid got=%b exp=0", f_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h3008) begin errors++; $display("FAIL stall_release_req got=%b/%h exp=1/00003008", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_exc_drop();
    fixed_data = 32'hDEAD_BEEF; mem_lat = 3;
    @(negedge clk); #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL exc_wait_noreq got=%b exp=0", imem_req_valid); end
    exc_req = 1'b1;
    @(negedge clk); exc_req = 1'b0; #1;
    checks++; if (f_pc !== EXC_A) begin errors++; $display("FAIL exc_fpc got=%h exp=%h", f_pc, EXC_A); end
    checks++; if (f_valid !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL exc_drop1 got=%b/%b exp=0/0", f_valid, imem_req_valid); end
    @(negedge clk); #1;
    checks++; if (f_valid !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL exc_drop2 got=%b/%b exp=0/0", f_valid, imem_req_valid); end
    @(negedge clk); #1;
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL exc_dropped_fvalid got=%b exp=0", f_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== EXC_A) begin errors++; $display("FAIL exc_req_addr got=%b/%h exp=1/%h", imem_req_valid, imem_req_addr, EXC_A); end
  endtask

  task automatic test_eret();
    int n;
    use_fixed = 1'b0; mem_lat = 1; stall = 1'b1;
    n = 0;
    for (int k = 1; k <= 10 && n == 0; k++) begin
      @(negedge clk); #1;
      if (f_valid === 1'b1) n = k;
    end
    checks++; if (f_valid !== 1'b1 || f_instr !== mword(EXC_A) || f_pc !== EXC_A) begin
      errors++; $display("FAIL eret_pre_fetch got=%b/%h/%h exp=1/%h/%h", f_valid, f_instr, f_pc, mword(EXC_A), EXC_A);
    end
    eret = 1'b1; epc = 32'h3010;
    @(negedge clk); eret = 1'b0; #1;
    checks++; if (f_valid !== 1'b0 || f_pc !== 32'h3010) begin errors++; $display("FAIL eret_redirect got=%b/%h exp=0/00003010", f_valid, f_pc); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h3010) begin errors++; $display("FAIL eret_req got=%b/%h exp=1/00003010", imem_req_valid, imem_req_addr); end
    stall = 1'b0;
  endtask

  task automatic test_adel_and_dual();
    int n;
    npc = 32'h3002;
    n = 0;
    for (int k = 1; k <= 10 && n == 0; k++) begin
      @(negedge clk); #1;
      if (f_valid === 1'b1) n = k;
    end
    checks++; if (n == 0) begin errors++; $display("FAIL adel_wait_fetch got=timeout exp=f_valid"); end
    @(negedge clk); #1;
    checks++; if (f_valid !== 1'b0 || imem_req_valid !== 1'b0 || f_pc !== 32'h3002) begin errors++; $display("FAIL misalign_noreq got=%b/%b/%h exp=0/0/00003002", f_valid, imem_req_valid, f_pc); end
    @(negedge clk); #1;
    checks++; if (f_valid !== 1'b1 || f_adel !== 1'b1 || f_instr !== 32'h0 || f_pc !== 32'h3002) begin
      errors++; $display("FAIL misalign_marker got=%b/%b/%h/%h exp=1/1/0/00003002", f_valid, f_adel, f_instr, f_pc);
    end
    npc = 32'h7000;
    @(negedge clk); #1;
    checks++; if (f_valid !== 1'b0 || imem_req_valid !== 1'b0 || f_pc !== 32'h7000) begin errors++; $display("FAIL range_noreq got=%b/%b/%h exp=0/0/00007000", f_valid, imem_req_valid, f_pc); end
    @(negedge clk); #1;
    checks++; if (f_valid !== 1'b1 || f_adel !== 1'b1 || f_instr !== 32'h0 || f_pc !== 32'h7000) begin
      errors++; $display("FAIL range_marker got=%b/%b/%h/%h exp=1/1/0/00007000", f_valid, f_adel, f_instr, f_pc);
    end
    exc_req = 1'b1; eret = 1'b1; epc = 32'h3020; imem_req_ready = 1'b0;
    @(negedge clk); exc_req = 1'b0; eret = 1'b0; #1;
    checks++; if (f_pc !== EXC_A || f_valid !== 1'b0 || f_adel !== 1'b0) begin errors++; $display("FAIL dual_redirect got=%h/%b/%b exp=%h/0/0", f_pc, f_valid, f_adel, EXC_A); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== EXC_A) begin errors++; $display("FAIL bp_req0 got=%b/%h exp=1/%h", imem_req_valid, imem_req_addr, EXC_A); end
    for (int k = 1; k < 4; k++) begin
      @(negedge clk); #1;
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== EXC_A) begin errors++; $display("FAIL bp_hold%0d got=%b/%h exp=1/%h", k, imem_req_valid, imem_req_addr, EXC_A); end
    end
    imem_req_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_accepted got=%b exp=0", imem_req_valid); end
    n = 0;
    for (int k = 1; k <= 10 && n == 0; k++) begin
      if (f_valid === 1'b1) n = k;
      else begin @(negedge clk); #1; end
    end
    checks++; if (f_valid !== 1'b1 || f_instr !== mword(EXC_A) || f_pc !== EXC_A) begin
      errors++; $display("FAIL bp_fetch got=%b/%h/%h exp=1/%h/%h", f_valid, f_instr, f_pc, mword(EXC_A), EXC_A);
    end
  endtask

  // Reference model: one buffered slot, one possibly-outstanding memory
  // transaction with a "stale" flag, PC updated by the redirect/consume rules.
  task automatic test_random();
    logic [31:0] m_pc = RST_PC, m_instr = 32'h0;
    logic        m_valid = 1'b0, m_adel = 1'b0, m_out = 1'b0, m_stale = 1'b0;
    logic        e_req, redir, hs, o_valid, o_out, o_stale;
    logic [31:0] o_pc;
    int          r;
    stray_en = 1'b1; lat_rand = 1'b1; use_fixed = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset   = (i == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
      exc_req = ($urandom_range(0, 29) == 0);
      eret    = ($urandom_range(0, 19) == 0);
      r = int'($urandom_range(0, 9));
      epc = (r < 7) ? (LO + (32'($urandom_range(0, 4095)) << 2)) : $urandom;
      stall = ($urandom_range(0, 3) == 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 9));
      if (r < 7) npc = m_pc + 32'd4;
      else if (r < 9) npc = LO + (32'($urandom_range(0, 4095)) << 2);
      else begin
        case ($urandom_range(0, 3))
          0: npc = 32'h3002;
          1: npc = 32'h7000;
          2: npc = 32'h2FFC;
          default: npc = 32'h6FFE;
        endcase
      end
      #1;
      redir = exc_req || eret;
      e_req = reset && !m_out && !m_valid && addr_legal(m_pc) && !redir;
      if (i > 0) begin
        checks++; if (imem_req_valid !== e_req) begin errors++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", i, imem_req_valid, e_req); end
        if (e_req) begin
          checks++; if (imem_req_addr !== m_pc) begin errors++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", i, imem_req_addr, m_pc); end
        end
        checks++; if (f_valid !== m_valid) begin errors++; $display("FAIL rnd_fvalid cyc=%0d got=%b exp=%b", i, f_valid, m_valid); end
        checks++; if (f_pc !== m_pc) begin errors++; $display("FAIL rnd_fpc cyc=%0d got=%h exp=%h", i, f_pc, m_pc); end
        checks++; if (f_adel !== m_adel) begin errors++; $display("FAIL rnd_fadel cyc=%0d got=%b exp=%b", i, f_adel, m_adel); end
        if (m_valid) begin
          checks++; if (f_instr !== m_instr) begin errors++; $display("FAIL rnd_finstr cyc=%0d got=%h exp=%h", i, f_instr, m_instr); end
        end
      end
      if (!reset) begin
        m_pc = RST_PC; m_instr = 32'h0; m_valid = 1'b0; m_adel = 1'b0; m_out = 1'b0; m_stale = 1'b0;
      end else begin
        hs = e_req && imem_req_ready;
        o_valid = m_valid; o_out = m_out; o_stale = m_stale; o_pc = m_pc;
        if (imem_resp_valid && o_out) begin
          if (!o_stale && !redir) begin m_valid = 1'b1; m_instr = imem_resp_data; m_adel = 1'b0; end
          m_out = 1'b0; m_stale = 1'b0;
        end
        if (redir) begin
          m_pc = exc_req ? EXC_A : epc; m_valid = 1'b0; m_adel = 1'b0;
          if (o_out && !imem_resp_valid) m_stale = 1'b1;
        end else begin
          if (hs) begin m_out = 1'b1; m_stale = 1'b0; end
          else if (!o_out && !o_valid && !addr_legal(o_pc)) begin m_valid = 1'b1; m_adel = 1'b1; m_instr = 32'h0; end
          if (o_valid && !stall) begin m_valid = 1'b0; m_adel = 1'b0; m_pc = npc; end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall();
    test_exc_drop();
    test_eret();
    test_adel_and_dual();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
